axi_lite_buffered_slave: RTL and testbench
==========================================

# axi_lite_buffered_slave

Parametrised AXI4-Lite slave endpoint that sits between the interconnect router and a peripheral's native request/done interface. It decouples the AW and W channels, so either may arrive first. It keeps up to DEPTH transactions outstanding per direction, with in-order response FIFOs. Out-of-range addresses complete locally with DECERR and produce no device request.

## Interface
- DATA_WIDTH, 32: data bus width, 32 or 64; strobe width is DATA_WIDTH/8
- ADDR_WIDTH, 32: address width
- LOW_SLAVE_ADDRESS, 32'h0000_0000: lowest decoded address, inclusive
- HIGH_SLAVE_ADDRESS, 32'hFFFF_FFFF: highest decoded address, inclusive
- DEPTH, 4: outstanding transactions per direction; power of two, ≥2
- axi_ACLK  in  1  clock
- axi_ARESETN  in  1  reset; asynchronous, active-low; clock axi_ACLK
- AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel
- WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
- ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address channel
- RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
- write_match_o, read_match_o  out  1  combinational: (addr in [LOW,HIGH]) & VALID, for the router
- write_busy_o, read_busy_o  out  1  direction has any captured or outstanding transaction
- write_request_o  out  1  device write request valid
- write_address_o/write_data_o/write_strobe_o  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  device write payload
- write_ready_i  in  1  device accepts write_request_o this cycle
- write_done_i, write_error_i  in  1  write completion pulse; error selects SLVERR
- read_request_o  out  1  device read request valid
- read_address_o  out  ADDR_WIDTH  device read address
- read_ready_i  in  1  device accepts read_request_o this cycle
- read_done_i, read_error_i  in  1  read completion pulse; error selects SLVERR
- read_data_i  in  DATA_WIDTH  read data, valid with read_done_i

## Operation
- Write path: one-entry AW slot and one-entry W slot, each filled independently.
  - AWREADY = live & !aw_full & (wr_credit < DEPTH).
  - WREADY = live & !w_full.
  - live is a flop reset to 0 and set on the first edge after reset release.
- Write issue, in range: write_request_o = aw_full & w_full & in_range(aw_addr). The payload comes from the slots. Both slots clear on the edge where write_request_o & write_ready_i.
- Write issue, out of range: when aw_full & w_full & !in_range & wr_pending==0, push DECERR (2'b11) into the B FIFO and clear both slots. No device request is made.
- B FIFO: DEPTH entries, 2 bits each.
  - write_done_i pushes write_error_i ? SLVERR (2'b10) : OKAY (2'b00).
  - BVALID = !empty; BRESP = head. Pop on BVALID & BREADY.
- wr_credit, width $clog2(DEPTH+1): +1 on AW handshake, -1 on B handshake; both in one cycle leave it unchanged. This guarantees the B FIFO never overflows.
- wr_pending: count of device requests accepted minus write_done_i pulses. It gates DECERR insertion so responses stay in order. The device must complete in order.
- Read path mirrors the write path:
  - AR slot; ARREADY = live & !ar_full & (rd_credit < DEPTH).
  - read_request_o = ar_full & in_range.
  - Out of range: push {0, DECERR} when rd_pending==0.
  - R FIFO entries are {read_data_i, resp}; RVALID = !empty; RDATA/RRESP = head.
- write_busy_o = aw_full | w_full | (wr_credit!=0). read_busy_o is defined analogously.
- Protocol violations are ignored, not corrected: write_done_i with wr_pending==0, or read_done_i with rd_pending==0.

## Timing
- Reset values: all READY=0, BVALID=RVALID=0, BRESP=RRESP=OKAY, RDATA=0, request outputs 0. FIFOs, slots, credits and pending counters are cleared; live=0.
- Reset mid-operation: all state is discarded immediately (asynchronous reset) and in-flight responses are lost. The first READY rises one cycle after release.
- Write latency: AW and W handshake at T0 → write_request_o at T1. With write_ready_i=1 at T1 and write_done_i at T2, BVALID=1 at T3.
- Read latency: AR at T0 → read_request_o at T1 → read_done_i at Tn → RVALID at Tn+1.
- A slot cannot refill in the same cycle it issues, giving one bubble. Sustained throughput is one transaction per 2 cycles per direction.
- VALID outputs stay asserted with stable payload until their READY is seen.
- FIFO push and pop in the same cycle: occupancy is unchanged. A pop on empty cannot occur.
- Pointers wrap modulo DEPTH; full/empty use an extra wrap bit.

## Test plan
- Setup for all scenarios: DATA_WIDTH=32, DEPTH=4, LOW=0x1000, HIGH=0x1FFF.
- W before AW: WDATA=0xDEADBEEF, WSTRB=0xF at T0; AWADDR=0x1004 at T3 → write_request_o at T4 with address 0x1004, data 0xDEADBEEF; done at T5 → BVALID, BRESP=OKAY at T6.
- Out of range: ARADDR=0x2000 → no read_request_o; RVALID with RRESP=2'b11, RDATA=0. write_match_o/read_match_o = 0 for this address.
- Credit limit: 5 back-to-back ARs to 0x1000..0x1010 with read_done_i held off and RREADY=0 → exactly 4 accepted, ARREADY=0 until the first R handshake.
- Ordering: write to 0x1000 pending at the device, then a write to 0x3000 → DECERR waits for the first done; BRESP sequence is OKAY then 2'b11.
- Backpressure: BREADY=0 for 10 cycles with BVALID=1 → BVALID and BRESP held stable; write_error_i=1 yields BRESP=2'b10.
- Reset: assert axi_ARESETN=0 with 2 outstanding reads → RVALID=0 immediately; ARREADY=0 until the edge after release, then 1.

Source files
------------

// File: rtl/axi_lite_buffered_slave.sv
// axi_lite_buffered_slave
//   AXI4-Lite slave endpoint between the interconnect router and a peripheral's
//   native request/done interface. AW and W are captured in independent
//   one-entry slots, so either may arrive first. Up to DEPTH transactions per
//   direction may be outstanding. Responses return through in-order FIFOs.
//   Addresses outside [LOW_SLAVE_ADDRESS, HIGH_SLAVE_ADDRESS] complete locally
//   with DECERR and never reach the device.
//
// Ports
//   axi_ACLK, axi_ARESETN        clock, asynchronous active-low reset
//   AW*/W*/B*/AR*/R*             AXI4-Lite slave channels
//   write_match_o/read_match_o   address decode hit for the router (combinational)
//   write_busy_o/read_busy_o     direction holds a captured or outstanding transaction
//   write_request_o ...          device write request/payload, write_ready_i accepts
//   write_done_i/write_error_i   device write completion (error -> SLVERR)
//   read_request_o ...           device read request/address, read_ready_i accepts
//   read_done_i/read_error_i     device read completion, read_data_i valid with done
module axi_lite_buffered_slave #(
  parameter int                    DATA_WIDTH         = 32,
  parameter int                    ADDR_WIDTH         = 32,
  parameter logic [ADDR_WIDTH-1:0] LOW_SLAVE_ADDRESS  = '0,
  parameter logic [ADDR_WIDTH-1:0] HIGH_SLAVE_ADDRESS = '1,
  parameter int                    DEPTH              = 4
) (
  input  logic                      axi_ACLK,
  input  logic                      axi_ARESETN,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      write_match_o,
  output logic                      read_match_o,
  output logic                      write_busy_o,
  output logic                      read_busy_o,
  output logic                      write_request_o,
  output logic [ADDR_WIDTH-1:0]     write_address_o,
  output logic [DATA_WIDTH-1:0]     write_data_o,
  output logic [DATA_WIDTH/8-1:0]   write_strobe_o,
  input  logic                      write_ready_i,
  input  logic                      write_done_i,
  input  logic                      write_error_i,
  output logic                      read_request_o,
  output logic [ADDR_WIDTH-1:0]     read_address_o,
  input  logic                      read_ready_i,
  input  logic                      read_done_i,
  input  logic                      read_error_i,
  input  logic [DATA_WIDTH-1:0]     read_data_i
);

  localparam int                   CNT_WIDTH   = $clog2(DEPTH + 1);
  localparam int                   PTR_WIDTH   = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT   = CNT_WIDTH'(DEPTH);
  localparam logic [1:0]           RESP_OKAY   = 2'b00;
  localparam logic [1:0]           RESP_SLVERR = 2'b10;
  localparam logic [1:0]           RESP_DECERR = 2'b11;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >= LOW_SLAVE_ADDRESS) && (addr <= HIGH_SLAVE_ADDRESS);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] step(input logic [CNT_WIDTH-1:0] cnt,
                                                input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + CNT_WIDTH'(1);
      2'b01:   return cnt - CNT_WIDTH'(1);
      default: return cnt;
    endcase
  endfunction

  // Holds all READYs low for the first cycle after reset release.
  logic live;

  logic                    aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [CNT_WIDTH-1:0]    wr_credit, rd_credit, wr_pending, rd_pending;

  logic aw_hs, w_hs, ar_hs, b_pop, r_pop;
  logic wr_accept, wr_decerr, wr_done_ok;
  logic rd_accept, rd_decerr, rd_done_ok;

  // Credits cover the whole life of a transaction (address handshake to
  // response handshake), so a response FIFO can never be pushed while full.
  assign AWREADY = live & ~aw_full & (wr_credit < DEPTH_CNT);
  assign WREADY  = live & ~w_full;
  assign ARREADY = live & ~ar_full & (rd_credit < DEPTH_CNT);

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  assign write_match_o = AWVALID & in_range(AWADDR);
  assign read_match_o  = ARVALID & in_range(ARADDR);

  assign write_request_o = aw_full & w_full & in_range(aw_addr);
  assign write_address_o = aw_addr;
  assign write_data_o    = w_data;
  assign write_strobe_o  = w_strb;
  assign wr_accept       = write_request_o & write_ready_i;
  // A DECERR waits until the device has drained, keeping B responses in order.
  assign wr_decerr       = aw_full & w_full & ~in_range(aw_addr) & (wr_pending == '0);
  assign wr_done_ok      = write_done_i & (wr_pending != '0);

  assign read_request_o = ar_full & in_range(ar_addr);
  assign read_address_o = ar_addr;
  assign rd_accept      = read_request_o & read_ready_i;
  assign rd_decerr      = ar_full & ~in_range(ar_addr) & (rd_pending == '0);
  assign rd_done_ok     = read_done_i & (rd_pending != '0);

  assign write_busy_o = aw_full | w_full | (wr_credit != '0);
  assign read_busy_o  = ar_full | (rd_credit != '0);

  // Response FIFOs: pointers carry an extra wrap bit for full/empty.
  logic [1:0]            b_mem [DEPTH];
  logic [PTR_WIDTH:0]    b_wptr, b_rptr;
  logic                  b_push;
  logic [1:0]            b_push_resp;
  logic [DATA_WIDTH+1:0] r_mem [DEPTH];
  logic [PTR_WIDTH:0]    r_wptr, r_rptr;
  logic                  r_push;
  logic [DATA_WIDTH+1:0] r_push_entry, r_head;

  assign b_push      = wr_done_ok | wr_decerr;
  assign b_push_resp = wr_decerr ? RESP_DECERR : (write_error_i ? RESP_SLVERR : RESP_OKAY);
  assign BVALID      = b_wptr != b_rptr;
  assign BRESP       = b_mem[b_rptr[PTR_WIDTH-1:0]];
  assign b_pop       = BVALID & BREADY;

  assign r_push       = rd_done_ok | rd_decerr;
  assign r_push_entry = rd_decerr ? {{DATA_WIDTH{1'b0}}, RESP_DECERR}
                                  : {read_data_i, (read_error_i ? RESP_SLVERR : RESP_OKAY)};
  assign r_head       = r_mem[r_rptr[PTR_WIDTH-1:0]];
  assign RVALID       = r_wptr != r_rptr;
  assign RDATA        = r_head[DATA_WIDTH+1:2];
  assign RRESP        = r_head[1:0];
  assign r_pop        = RVALID & RREADY;

  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      live       <= 1'b0;
      aw_full    <= 1'b0;
      w_full     <= 1'b0;
      ar_full    <= 1'b0;
      aw_addr    <= '0;
      ar_addr    <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      wr_credit  <= '0;
      rd_credit  <= '0;
      wr_pending <= '0;
      rd_pending <= '0;
    end else begin
      live <= 1'b1;
      // Handshake and issue are exclusive per slot (READY needs the slot empty).
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
      end else if (wr_accept | wr_decerr) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end else if (wr_accept | wr_decerr) begin
        w_full <= 1'b0;
      end
      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_addr <= ARADDR;
      end else if (rd_accept | rd_decerr) begin
        ar_full <= 1'b0;
      end
      wr_credit  <= step(wr_credit, aw_hs, b_pop);
      rd_credit  <= step(rd_credit, ar_hs, r_pop);
      wr_pending <= step(wr_pending, wr_accept, wr_done_ok);
      rd_pending <= step(rd_pending, rd_accept, rd_done_ok);
    end
  end

  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        b_mem[i] <= '0;
        r_mem[i] <= '0;
      end
      b_wptr <= '0;
      b_rptr <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (b_push) begin
        b_mem[b_wptr[PTR_WIDTH-1:0]] <= b_push_resp;
        b_wptr <= b_wptr + 1'b1;
      end
      if (b_pop) b_rptr <= b_rptr + 1'b1;
      if (r_push) begin
        r_mem[r_wptr[PTR_WIDTH-1:0]] <= r_push_entry;
        r_wptr <= r_wptr + 1'b1;
      end
      if (r_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_lite_buffered_slave.sv
// Directed testbench for axi_lite_buffered_slave (DATA_WIDTH=32, DEPTH=4,
// decoded window 0x1000..0x1FFF). Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point.
module tb_axi_lite_buffered_slave;

  logic        axi_ACLK;
  logic        axi_ARESETN;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        write_match_o, read_match_o;
  logic        write_busy_o, read_busy_o;
  logic        write_request_o;
  logic [31:0] write_address_o;
  logic [31:0] write_data_o;
  logic [3:0]  write_strobe_o;
  logic        write_ready_i, write_done_i, write_error_i;
  logic        read_request_o;
  logic [31:0] read_address_o;
  logic        read_ready_i, read_done_i, read_error_i;
  logic [31:0] read_data_i;

  int checks = 0;
  int errors = 0;

  axi_lite_buffered_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .LOW_SLAVE_ADDRESS(32'h0000_1000), .HIGH_SLAVE_ADDRESS(32'h0000_1FFF),
    .DEPTH(4)
  ) dut (
    .axi_ACLK(axi_ACLK), .axi_ARESETN(axi_ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .write_match_o(write_match_o), .read_match_o(read_match_o),
    .write_busy_o(write_busy_o), .read_busy_o(read_busy_o),
    .write_request_o(write_request_o), .write_address_o(write_address_o),
    .write_data_o(write_data_o), .write_strobe_o(write_strobe_o),
    .write_ready_i(write_ready_i), .write_done_i(write_done_i),
    .write_error_i(write_error_i),
    .read_request_o(read_request_o), .read_address_o(read_address_o),
    .read_ready_i(read_ready_i), .read_done_i(read_done_i),
    .read_error_i(read_error_i), .read_data_i(read_data_i)
  );

  initial begin
    axi_ACLK = 1'b0;
    forever #5 axi_ACLK = ~axi_ACLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge axi_ACLK);
    #1;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    while (!WREADY && n < 50) begin tick(); n++; end
    checks++;
    if (WREADY !== 1'b1) begin
      errors++;
      $display("FAIL w_handshake_timeout: WREADY=%b required 1", WREADY);
    end
    tick();
    WVALID = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] addr);
    int n = 0;
    AWADDR = addr; AWVALID = 1'b1;
    while (!AWREADY && n < 50) begin tick(); n++; end
    checks++;
    if (AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL aw_handshake_timeout: AWREADY=%b required 1", AWREADY);
    end
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr);
    int n = 0;
    ARADDR = addr; ARVALID = 1'b1;
    while (!ARREADY && n < 50) begin tick(); n++; end
    checks++;
    if (ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL ar_handshake_timeout: ARREADY=%b required 1", ARREADY);
    end
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic test_reset();
    axi_ARESETN = 1'b0;
    repeat (3) tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b required 000", {AWREADY, WREADY, ARREADY});
    end
    checks++;
    if ({BVALID, RVALID} !== 2'b00) begin
      errors++; $display("FAIL reset_valid: got %b required 00", {BVALID, RVALID});
    end
    checks++;
    if (BRESP !== 2'b00 || RRESP !== 2'b00 || RDATA !== 32'h0) begin
      errors++; $display("FAIL reset_payload: BRESP=%b RRESP=%b RDATA=%h required 00 00 0", BRESP, RRESP, RDATA);
    end
    checks++;
    if ({write_request_o, read_request_o, write_busy_o, read_busy_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_req_busy: got %b required 0000",
                         {write_request_o, read_request_o, write_busy_o, read_busy_o});
    end
    axi_ARESETN = 1'b1;
    #1;
    checks++;
    if (ARREADY !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready_early: ARREADY=%b required 0", ARREADY);
    end
    tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++; $display("FAIL reset_release_ready: got %b required 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_w_before_aw();
    send_w(32'hDEADBEEF, 4'hF);
    checks++;
    if ({WREADY, write_request_o, write_busy_o} !== 3'b001) begin
      errors++; $display("FAIL w_only_state: WREADY/req/busy=%b required 001",
                         {WREADY, write_request_o, write_busy_o});
    end
    repeat (2) tick();
    send_aw(32'h0000_1004);
    checks++;
    if (write_request_o !== 1'b1 || write_address_o !== 32'h1004 ||
        write_data_o !== 32'hDEADBEEF || write_strobe_o !== 4'hF) begin
      errors++; $display("FAIL w_before_aw_request: req=%b addr=%h data=%h strb=%h required 1 1004 deadbeef f",
                         write_request_o, write_address_o, write_data_o, write_strobe_o);
    end
    write_ready_i = 1'b1;
    tick();
    write_ready_i = 1'b0;
    checks++;
    if ({write_request_o, BVALID} !== 2'b00) begin
      errors++; $display("FAIL w_after_accept: req/BVALID=%b required 00", {write_request_o, BVALID});
    end
    write_done_i = 1'b1;
    tick();
    write_done_i = 1'b0;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      errors++; $display("FAIL w_bresp: BVALID=%b BRESP=%b required 1 00", BVALID, BRESP);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checks++;
    if ({BVALID, write_busy_o} !== 2'b00) begin
      errors++; $display("FAIL w_drained: BVALID/busy=%b required 00", {BVALID, write_busy_o});
    end
  endtask

  task automatic test_read_in_range();
    send_ar(32'h0000_1008);
    checks++;
    if (read_request_o !== 1'b1 || read_address_o !== 32'h1008) begin
      errors++; $display("FAIL rd_request: req=%b addr=%h required 1 1008", read_request_o, read_address_o);
    end
    read_ready_i = 1'b1;
    tick();
    read_ready_i = 1'b0;
    checks++;
    if ({read_request_o, RVALID} !== 2'b00) begin
      errors++; $display("FAIL rd_after_accept: req/RVALID=%b required 00", {read_request_o, RVALID});
    end
    read_data_i = 32'h1234_5678; read_done_i = 1'b1;
    tick();
    read_done_i = 1'b0; read_data_i = 32'h0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h1234_5678 || RRESP !== 2'b00) begin
      errors++; $display("FAIL rd_response: RVALID=%b RDATA=%h RRESP=%b required 1 12345678 00", RVALID, RDATA, RRESP);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    checks++;
    if (RVALID !== 1'b0) begin
      errors++; $display("FAIL rd_drained: RVALID=%b required 0", RVALID);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [4];
    logic [3:0]  exp_match;
    addrs = '{32'h0000_0FFF, 32'h0000_1000, 32'h0000_1FFF, 32'h0000_2000};
    exp_match = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      ARADDR = addrs[i]; ARVALID = 1'b1; AWADDR = addrs[i]; AWVALID = 1'b1;
      #1;
      checks++;
      if (read_match_o !== exp_match[i] || write_match_o !== exp_match[i]) begin
        errors++; $display("FAIL match_%h: rd=%b wr=%b required %b", addrs[i],
                           read_match_o, write_match_o, exp_match[i]);
      end
      ARVALID = 1'b0; AWVALID = 1'b0;
      tick();
    end
    send_ar(32'h0000_2000);
    checks++;
    if (read_request_o !== 1'b0) begin
      errors++; $display("FAIL oor_no_request: req=%b required 0", read_request_o);
    end
    tick();
    checks++;
    if (RVALID !== 1'b1 || RRESP !== 2'b11 || RDATA !== 32'h0 || read_request_o !== 1'b0) begin
      errors++; $display("FAIL oor_decerr: RVALID=%b RRESP=%b RDATA=%h req=%b required 1 11 0 0",
                         RVALID, RRESP, RDATA, read_request_o);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
  endtask

  task automatic test_credit_limit();
    int acc = 0;
    logic hs;
    read_ready_i = 1'b1;
    ARADDR = 32'h0000_1000; ARVALID = 1'b1;
    for (int c = 0; c < 20; c++) begin
      hs = ARREADY;
      tick();
      if (hs) begin
        acc++;
        ARADDR = 32'h0000_1000 + 32'(4 * acc);
      end
    end
    checks++;
    if (acc != 4 || ARREADY !== 1'b0) begin
      errors++; $display("FAIL credit_accepted: accepted=%0d ARREADY=%b required 4 0", acc, ARREADY);
    end
    read_data_i = 32'h0000_00A0; read_done_i = 1'b1;
    tick();
    read_done_i = 1'b0;
    repeat (2) tick();
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'hA0 || ARREADY !== 1'b0) begin
      errors++; $display("FAIL credit_hold: RVALID=%b RDATA=%h ARREADY=%b required 1 a0 0", RVALID, RDATA, ARREADY);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    checks++;
    if (ARREADY !== 1'b1) begin
      errors++; $display("FAIL credit_release: ARREADY=%b required 1", ARREADY);
    end
    tick();
    ARVALID = 1'b0;
    checks++;
    if (read_request_o !== 1'b1 || read_address_o !== 32'h1010) begin
      errors++; $display("FAIL credit_fifth: req=%b addr=%h required 1 1010", read_request_o, read_address_o);
    end
    tick();
    for (int j = 1; j <= 4; j++) begin
      read_data_i = 32'h0000_00A0 + 32'(j); read_done_i = 1'b1;
      tick();
      read_done_i = 1'b0;
      checks++;
      if (RVALID !== 1'b1 || RDATA !== 32'h0000_00A0 + 32'(j)) begin
        errors++; $display("FAIL credit_order_%0d: RVALID=%b RDATA=%h required 1 %h", j, RVALID, RDATA,
                           32'h0000_00A0 + 32'(j));
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
    read_ready_i = 1'b0;
    checks++;
    if ({RVALID, read_busy_o} !== 2'b00) begin
      errors++; $display("FAIL credit_drained: RVALID/busy=%b required 00", {RVALID, read_busy_o});
    end
  endtask

  task automatic test_ordering();
    write_ready_i = 1'b1;
    send_w(32'h1111_1111, 4'hF);
    send_aw(32'h0000_1000);
    send_w(32'h2222_2222, 4'hF);
    send_aw(32'h0000_3000);
    write_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({BVALID, write_request_o} !== 2'b00) begin
        errors++; $display("FAIL order_wait_%0d: BVALID/req=%b required 00", c, {BVALID, write_request_o});
      end
      tick();
    end
    write_done_i = 1'b1;
    tick();
    write_done_i = 1'b0;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      errors++; $display("FAIL order_first: BVALID=%b BRESP=%b required 1 00", BVALID, BRESP);
    end
    BREADY = 1'b1;
    tick();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b11) begin
      errors++; $display("FAIL order_second: BVALID=%b BRESP=%b required 1 11", BVALID, BRESP);
    end
    tick();
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++; $display("FAIL order_drained: BVALID=%b required 0", BVALID);
    end
  endtask

  task automatic test_backpressure();
    write_ready_i = 1'b1;
    send_w(32'hCAFE_F00D, 4'h3);
    send_aw(32'h0000_1100);
    checks++;
    if (write_request_o !== 1'b1 || write_strobe_o !== 4'h3 || write_data_o !== 32'hCAFEF00D) begin
      errors++; $display("FAIL bp_request: req=%b strb=%h data=%h required 1 3 cafef00d",
                         write_request_o, write_strobe_o, write_data_o);
    end
    tick();
    write_ready_i = 1'b0;
    write_error_i = 1'b1; write_done_i = 1'b1;
    tick();
    write_done_i = 1'b0; write_error_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (BVALID !== 1'b1 || BRESP !== 2'b10) begin
        errors++; $display("FAIL bp_hold_%0d: BVALID=%b BRESP=%b required 1 10", c, BVALID, BRESP);
      end
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++; $display("FAIL bp_drained: BVALID=%b required 0", BVALID);
    end
  endtask

  task automatic test_reset_mid();
    read_ready_i = 1'b1;
    send_ar(32'h0000_1010);
    tick();
    send_ar(32'h0000_1014);
    tick();
    read_ready_i = 1'b0;
    read_done_i = 1'b1; read_data_i = 32'h1;
    tick();
    read_data_i = 32'h2;
    tick();
    read_done_i = 1'b0; read_data_i = 32'h0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h1) begin
      errors++; $display("FAIL mid_pre: RVALID=%b RDATA=%h required 1 1", RVALID, RDATA);
    end
    axi_ARESETN = 1'b0;
    #1;
    checks++;
    if ({RVALID, ARREADY, read_busy_o} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_immediate: RVALID/ARREADY/busy=%b required 000",
                         {RVALID, ARREADY, read_busy_o});
    end
    repeat (2) tick();
    axi_ARESETN = 1'b1;
    #1;
    checks++;
    if (ARREADY !== 1'b0) begin
      errors++; $display("FAIL mid_release_early: ARREADY=%b required 0", ARREADY);
    end
    tick();
    checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      errors++; $display("FAIL mid_release: ARREADY=%b RVALID=%b required 1 0", ARREADY, RVALID);
    end
  endtask

  initial begin
    axi_ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    write_ready_i = 1'b0; write_done_i = 1'b0; write_error_i = 1'b0;
    read_ready_i = 1'b0; read_done_i = 1'b0; read_error_i = 1'b0; read_data_i = '0;

    test_reset();
    test_w_before_aw();
    test_read_in_range();
    test_out_of_range();
    test_credit_limit();
    test_ordering();
    test_backpressure();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
